// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a contiguous block of a synchronous RAM from a
// base address, hides the RAM's 1-cycle read latency and re-emits the words
// as a valid/ready stream through a 4-entry shift-register FIFO whose entry 0
// is the output register.
// Optional build macro: RAM_RD_STRIDE_EN adds a stride_i port; the address then
// advances by the captured stride per issued read instead of by one.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
`ifdef RAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
);

  typedef logic [ADDR_WIDTH:0]   len_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_RUN, S_DRAIN} state_e;

  localparam addr_t ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam len_t  LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam len_t  LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};

  // Control state
  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  addr_t  ram_addr_q, ram_addr_d;
  addr_t  addr_q, addr_d;           // next address to issue
  len_t   len_q, len_d;
  len_t   issued_q, issued_d;
  // Read pipeline tags: tag1 = address on RAM port, tag2 = data on ram_q_i
  logic   tag1_q, tag1_d, tag1_last_q, tag1_last_d;
  logic   tag2_q, tag2_d, tag2_last_q, tag2_last_d;

  // FIFO state; entry 0 drives the stream outputs directly
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [FIFO_DEPTH];
  logic                  last_q [FIFO_DEPTH];
  logic                  last_d [FIFO_DEPTH];
  logic [2:0]            cnt_q, cnt_d;
  logic                  vld_q, vld_d;

  logic       pop_s;
  logic       push_s;
  logic [3:0] occ_s;
  logic [2:0] wr_full_s;
  logic [1:0] wr_idx_s;
  addr_t      start_step_s;
  addr_t      run_step_s;

`ifdef RAM_RD_STRIDE_EN
  addr_t stride_q, stride_d;
  assign start_step_s = stride_i;
  assign run_step_s   = stride_q;
`else
  assign start_step_s = ADDR_ONE;
  assign run_step_s   = ADDR_ONE;
`endif

  assign pop_s  = vld_q & m_ready_i;
  assign push_s = tag2_q;
  // Occupancy counts words already stored plus words still in the RAM pipe
  assign occ_s  = {1'b0, cnt_q} + {3'b000, tag1_q} + {3'b000, tag2_q};

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_we_o   = 1'b0;
  assign m_data_o   = data_q[0];
  assign m_valid_o  = vld_q;
  assign m_last_o   = last_q[0];

  // Next-state logic for the command FSM, address generator and read tags
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ram_addr_d  = ram_addr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    tag1_d      = 1'b0;
    tag1_last_d = 1'b0;
    tag2_d      = tag1_q;
    tag2_last_d = tag1_last_q;
`ifdef RAM_RD_STRIDE_EN
    stride_d    = stride_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d  = length_i;
          busy_d = 1'b1;
`ifdef RAM_RD_STRIDE_EN
          stride_d = stride_i;
`endif
          if (length_i == LEN_ZERO) begin
            issued_d = LEN_ZERO;
            state_d  = S_ZERO;
          end else begin
            // First read issues on the accepting edge so the address is out a cycle early
            ram_addr_d  = base_addr_i;
            addr_d      = base_addr_i + start_step_s;
            issued_d    = LEN_ONE;
            tag1_d      = 1'b1;
            tag1_last_d = (length_i == LEN_ONE);
            state_d     = (length_i == LEN_ONE) ? S_DRAIN : S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ZERO: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RUN: begin
        if ((issued_q < len_q) && (occ_s < 4'(FIFO_DEPTH))) begin
          ram_addr_d  = addr_q;
          addr_d      = addr_q + run_step_s;
          issued_d    = issued_q + LEN_ONE;
          tag1_d      = 1'b1;
          tag1_last_d = ((issued_q + LEN_ONE) == len_q);
          if ((issued_q + LEN_ONE) == len_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (pop_s && last_q[0]) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Next-state logic for the shift-register FIFO: pop shifts down, push fills the first free slot
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      data_d[i] = data_q[i];
      last_d[i] = last_q[i];
    end
    wr_full_s = cnt_q - {2'b00, pop_s};
    wr_idx_s  = wr_full_s[1:0];
    if (pop_s) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
        // Slots beyond the occupancy may hold stale tags; never shift those into view
        if (cnt_q > 3'(i + 1)) begin
          last_d[i] = last_q[i+1];
        end else begin
          last_d[i] = 1'b0;
        end
      end
      last_d[FIFO_DEPTH-1] = 1'b0;
    end else begin
      last_d[FIFO_DEPTH-1] = last_q[FIFO_DEPTH-1];
    end
    if (push_s) begin
      data_d[wr_idx_s] = ram_q_i;
      last_d[wr_idx_s] = tag2_last_q;
    end else begin
      wr_idx_s = wr_full_s[1:0];
    end
    cnt_d = cnt_q + {2'b00, push_s} - {2'b00, pop_s};
    vld_d = (cnt_d != 3'd0);
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_addr_q  <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      tag1_q      <= 1'b0;
      tag1_last_q <= 1'b0;
      tag2_q      <= 1'b0;
      tag2_last_q <= 1'b0;
`ifdef RAM_RD_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ram_addr_q  <= ram_addr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      tag1_q      <= tag1_d;
      tag1_last_q <= tag1_last_d;
      tag2_q      <= tag2_d;
      tag2_last_q <= tag2_last_d;
`ifdef RAM_RD_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end

  // FIFO registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      cnt_q <= 3'd0;
      vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= data_d[i];
        last_q[i] <= last_d[i];
      end
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

endmodule
